ca_rule_sequencer: RTL and testbench

Frame-synchronous controller for the 1-D cellular-automaton VGA datapath. It selects the Wolfram rule number the cell-update logic applies, schedules automatic rule changes every epoch of frames, and handles reseed, pause and manual-advance requests from the user inputs. All configuration changes take effect only at a frame boundary, so every displayed frame is computed with one stable configuration. Sits between the `ui_in` pins / timing generator and the CA row engine plus colour mapper.

---
 rtl/ca_rule_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_ca_rule_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_rule_sequencer.sv
// ca_rule_sequencer: frame-synchronous rule selection, epoch scheduling and
// reseed / pause / next-rule handling for the 1-D cellular-automaton VGA datapath.
module ca_rule_sequencer #(
   parameter int                   N_RULES      = 4,
   parameter logic [8*N_RULES-1:0] RULE_TABLE   = {8'd184, 8'd90, 8'd110, 8'd30},
   parameter logic [6*N_RULES-1:0] PALETTE      = {6'b110100, 6'b010111, 6'b001011, 6'b101100},
   parameter int                   EPOCH_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_start,
   input  logic       btn_reseed,
   input  logic       btn_next,
   input  logic       btn_pause,
   input  logic       manual,
   output logic [7:0] rule,
   output logic [3:0] rule_idx,
   output logic [5:0] color,
   output logic       seed,
   output logic       scroll_en
);

   localparam int               CNT_W    = $clog2(EPOCH_FRAMES) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(EPOCH_FRAMES - 1);
   localparam logic [3:0]       LAST_IDX = 4'(N_RULES - 1);

   localparam logic [1:0] ST_SEED  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   // Input conditioning
   logic [1:0] reseed_sync, next_sync, pause_sync, manual_sync;
   logic       reseed_d, next_d, pause_d;
   logic       rise_reseed, rise_next, rise_pause;
   logic       manual_s;

   assign rise_reseed = reseed_sync[1] & ~reseed_d;
   assign rise_next   = next_sync[1]   & ~next_d;
   assign rise_pause  = pause_sync[1]  & ~pause_d;
   assign manual_s    = manual_sync[1];

   // Control state
   logic [1:0]       state, state_nxt;
   logic             seed_cnt, seed_cnt_nxt;
   logic [CNT_W-1:0] frame_cnt, frame_cnt_nxt;
   logic [3:0]       rule_idx_nxt;
   logic             p_reseed, p_next, p_pause;
   logic             clr_reseed, clr_next, clr_pause;

   function automatic logic [3:0] inc_idx(input logic [3:0] idx);
      return (idx >= LAST_IDX) ? 4'd0 : idx + 4'd1;
   endfunction

   // Every decision is taken only on the frame_start cycle, so one frame always
   // sees a single configuration.
   // NOTE: every always_comb output gets a default first, so no latch can be inferred.
   always_comb begin
      state_nxt     = state;
      seed_cnt_nxt  = seed_cnt;
      frame_cnt_nxt = frame_cnt;
      rule_idx_nxt  = rule_idx;
      clr_reseed    = 1'b0;
      clr_next      = 1'b0;
      clr_pause     = 1'b0;

      if (frame_start) begin
         case (state)
            ST_SEED: begin
               // The first pulse ends the partial frame; the second ends the full seeded one.
               if (seed_cnt) begin
                  state_nxt    = ST_RUN;
                  seed_cnt_nxt = 1'b0;
               end else begin
                  seed_cnt_nxt = 1'b1;
               end
            end

            ST_RUN: begin
               if (p_reseed) begin
                  state_nxt     = ST_SEED;
                  seed_cnt_nxt  = 1'b0;
                  frame_cnt_nxt = '0;
                  clr_reseed    = 1'b1;
                  clr_next      = 1'b1;
                  clr_pause     = 1'b1;
               end else if (p_next) begin
                  rule_idx_nxt  = inc_idx(rule_idx);
                  frame_cnt_nxt = '0;
                  clr_next      = 1'b1;
                  if (p_pause) begin
                     state_nxt = ST_PAUSE;
                     clr_pause = 1'b1;
                  end
               end else if (p_pause) begin
                  state_nxt = ST_PAUSE;
                  clr_pause = 1'b1;
               end else if (!manual_s) begin
                  if (frame_cnt >= LAST_CNT) begin
                     frame_cnt_nxt = '0;
                     rule_idx_nxt  = inc_idx(rule_idx);
                  end else begin
                     frame_cnt_nxt = frame_cnt + CNT_W'(1);
                  end
               end
            end

            ST_PAUSE: begin
               if (p_reseed) begin
                  state_nxt     = ST_SEED;
                  seed_cnt_nxt  = 1'b0;
                  frame_cnt_nxt = '0;
                  clr_reseed    = 1'b1;
                  clr_next      = 1'b1;
                  clr_pause     = 1'b1;
               end else begin
                  if (p_next) begin
                     rule_idx_nxt = inc_idx(rule_idx);
                     clr_next     = 1'b1;
                  end
                  if (p_pause) begin
                     state_nxt = ST_RUN;
                     clr_pause = 1'b1;
                  end
               end
            end

            default: begin
               state_nxt    = ST_SEED;
               seed_cnt_nxt = 1'b0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reseed_sync <= 2'b00;
         next_sync   <= 2'b00;
         pause_sync  <= 2'b00;
         manual_sync <= 2'b00;
         reseed_d    <= 1'b0;
         next_d      <= 1'b0;
         pause_d     <= 1'b0;
         p_reseed    <= 1'b0;
         p_next      <= 1'b0;
         p_pause     <= 1'b0;
         state       <= ST_SEED;
         seed_cnt    <= 1'b0;
         frame_cnt   <= '0;
         rule_idx    <= 4'd0;
      end else begin
         reseed_sync <= {reseed_sync[0], btn_reseed};
         next_sync   <= {next_sync[0],   btn_next};
         pause_sync  <= {pause_sync[0],  btn_pause};
         manual_sync <= {manual_sync[0], manual};
         reseed_d    <= reseed_sync[1];
         next_d      <= next_sync[1];
         pause_d     <= pause_sync[1];
         // A new edge wins over consumption so a press on the boundary is not lost.
         p_reseed    <= rise_reseed | (p_reseed & ~clr_reseed);
         p_next      <= rise_next   | (p_next   & ~clr_next);
         p_pause     <= rise_pause  | (p_pause  & ~clr_pause);
         state       <= state_nxt;
         seed_cnt    <= seed_cnt_nxt;
         frame_cnt   <= frame_cnt_nxt;
         rule_idx    <= rule_idx_nxt;
      end
   end

   assign seed      = (state == ST_SEED);
   assign scroll_en = (state == ST_RUN);

   always_comb begin
      rule  = 8'd0;
      color = 6'd0;
      for (int i = 0; i < N_RULES; i++) begin
         if (rule_idx == 4'(i)) begin
            rule  = RULE_TABLE[8*i +: 8];
            color = PALETTE[6*i +: 6];
         end
      end
   end

endmodule

// File: tb/tb_ca_rule_sequencer.sv
// Self-checking bench for ca_rule_sequencer: per-frame expectations are queued
// with each frame_start pulse and compared every cycle of the resulting frame.
module tb_ca_rule_sequencer;

   localparam int FRAME_LEN = 12;

   typedef struct packed {
      logic       seed;
      logic       scroll;
      logic [3:0] idx;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_start = 1'b0;
   logic       btn_reseed = 1'b0;
   logic       btn_next = 1'b0;
   logic       btn_pause = 1'b0;
   logic       manual = 1'b0;
   logic [7:0] rule;
   logic [3:0] rule_idx;
   logic [5:0] color;
   logic       seed;
   logic       scroll_en;

   ca_rule_sequencer #(.EPOCH_FRAMES(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .btn_reseed  (btn_reseed),
      .btn_next    (btn_next),
      .btn_pause   (btn_pause),
      .manual      (manual),
      .rule        (rule),
      .rule_idx    (rule_idx),
      .color       (color),
      .seed        (seed),
      .scroll_en   (scroll_en)
   );

   always #5 clk = ~clk;

   logic [7:0] rule_tab  [4] = '{8'd30, 8'd110, 8'd90, 8'd184};
   logic [5:0] color_tab [4] = '{6'b101100, 6'b001011, 6'b010111, 6'b110100};

   exp_t  exp_q[$];
   int    checks = 0;
   int    errors = 0;
   bit    mon_en = 1'b0;
   logic  fs_q = 1'b0;
   logic  rst_q = 1'b0;
   exp_t  cur;
   logic [19:0] obs;

   assign obs = {seed, scroll_en, rule_idx, rule, color};

   function automatic exp_t mk(input logic s, input logic r, input int i);
      exp_t e;
      e.seed   = s;
      e.scroll = r;
      e.idx    = 4'(i);
      return e;
   endfunction

   function automatic logic [19:0] expv(input exp_t e);
      return {e.seed, e.scroll, e.idx, rule_tab[e.idx[1:0]], color_tab[e.idx[1:0]]};
   endfunction

   // Scoreboard: a frame_start accepted at a clock edge releases the next expectation,
   // which must then hold on every cycle until the next accepted frame_start or reset.
   always @(posedge clk) begin
      fs_q  <= frame_start;
      rst_q <= rst_n;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (!rst_q) begin
            cur = mk(1'b1, 1'b0, 0);
         end else if (fs_q) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_underflow at %0t: frame accepted with no expectation queued", $time);
            end else begin
               cur = exp_q.pop_front();
            end
         end
         checks++;
         if (obs !== expv(cur)) begin
            errors++;
            $display("FAIL frame_outputs at %0t: got seed=%b scroll_en=%b rule_idx=%0d rule=%0d color=%b, want seed=%b scroll_en=%b rule_idx=%0d rule=%0d color=%b",
                     $time, obs[19], obs[18], obs[17:14], obs[13:6], obs[5:0],
                     cur.seed, cur.scroll, cur.idx, rule_tab[cur.idx[1:0]], color_tab[cur.idx[1:0]]);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_frame(input exp_t e);
      exp_q.push_back(e);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic frame(input exp_t e);
      pulse_frame(e);
      idle(FRAME_LEN - 1);
   endtask

   // m = {reseed, next, pause}
   task automatic tap(input logic [2:0] m);
      {btn_reseed, btn_next, btn_pause} = m;
      idle(3);
      {btn_reseed, btn_next, btn_pause} = 3'b000;
      idle(2);
   endtask

   task automatic test_reset();
      idle(2);
      frame_start = 1'b1;        // must be ignored while in reset
      @(negedge clk);
      frame_start = 1'b0;
      idle(1);
      checks++;
      if (obs !== expv(mk(1'b1, 1'b0, 0))) begin
         errors++;
         $display("FAIL reset_state: got %h, want %h", obs, expv(mk(1'b1, 1'b0, 0)));
      end
      cur    = mk(1'b1, 1'b0, 0);
      mon_en = 1'b1;
      rst_n  = 1'b1;
      idle(1);
      frame(mk(1'b1, 1'b0, 0));
      frame(mk(1'b0, 1'b1, 0));
      frame(mk(1'b0, 1'b1, 0));
      checks++;
      if ({seed, scroll_en, rule} !== {1'b0, 1'b1, 8'd30}) begin
         errors++;
         $display("FAIL run_after_seed: got seed=%b scroll_en=%b rule=%0d, want seed=0 scroll_en=1 rule=30",
                  seed, scroll_en, rule);
      end
   endtask

   task automatic test_auto_epoch();
      // k counts RUN frames since entering RUN; two have already been shown.
      for (int k = 2; k <= 12; k++) frame(mk(1'b0, 1'b1, (k / 3) % 4));
      checks++;
      if (rule !== 8'd30) begin
         errors++;
         $display("FAIL epoch_wrap: got rule=%0d, want 30", rule);
      end
   endtask

   task automatic test_pause();
      tap(3'b001);
      checks++;
      if (scroll_en !== 1'b1) begin
         errors++;
         $display("FAIL pause_not_early: got scroll_en=%b before frame_start, want 1", scroll_en);
      end
      for (int i = 0; i < 4; i++) frame(mk(1'b0, 1'b0, 0));
      tap(3'b001);
      frame(mk(1'b0, 1'b1, 0));
      frame(mk(1'b0, 1'b1, 0));
      frame(mk(1'b0, 1'b1, 0));
      frame(mk(1'b0, 1'b1, 1));
   endtask

   task automatic test_reseed_next();
      tap(3'b110);
      frame(mk(1'b1, 1'b0, 1));
      frame(mk(1'b1, 1'b0, 1));
      frame(mk(1'b0, 1'b1, 1));
      frame(mk(1'b0, 1'b1, 1));
      frame(mk(1'b0, 1'b1, 1));
      frame(mk(1'b0, 1'b1, 2));
      checks++;
      if (rule !== 8'd90) begin
         errors++;
         $display("FAIL reseed_next_result: got rule=%0d, want 90", rule);
      end
   endtask

   task automatic test_manual();
      rst_n  = 1'b0;
      manual = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(1);
      frame(mk(1'b1, 1'b0, 0));
      for (int i = 0; i < 201; i++) frame(mk(1'b0, 1'b1, 0));
      checks++;
      if (rule !== 8'd30) begin
         errors++;
         $display("FAIL manual_hold: got rule=%0d, want 30", rule);
      end
      // Press mid-frame, then a second edge timed to land on the frame_start edge.
      pulse_frame(mk(1'b0, 1'b1, 0));
      idle(2);
      btn_next = 1'b1;
      idle(3);
      btn_next = 1'b0;
      idle(FRAME_LEN - 6);
      btn_next = 1'b1;
      idle(2);
      pulse_frame(mk(1'b0, 1'b1, 1));
      idle(3);
      btn_next = 1'b0;
      idle(FRAME_LEN - 4);
      frame(mk(1'b0, 1'b1, 2));
      // A press held across ten frames advances once.
      btn_next = 1'b1;
      idle(4);
      for (int i = 0; i < 10; i++) frame(mk(1'b0, 1'b1, 3));
      btn_next = 1'b0;
      idle(4);
      frame(mk(1'b0, 1'b1, 3));
      frame(mk(1'b0, 1'b1, 3));
   endtask

   task automatic test_reset_in_pause();
      tap(3'b001);
      frame(mk(1'b0, 1'b0, 3));
      for (int j = 0; j < 3; j++) begin
         tap(3'b010);
         frame(mk(1'b0, 1'b0, j));
      end
      idle(3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if ({rule, seed, scroll_en} !== {8'd30, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_in_pause: got rule=%0d seed=%b scroll_en=%b, want rule=30 seed=1 scroll_en=0",
                  rule, seed, scroll_en);
      end
      idle(1);
   endtask

   task automatic test_back_to_back();
      pulse_frame(mk(1'b1, 1'b0, 0));
      idle(1);
      pulse_frame(mk(1'b0, 1'b1, 0));
      idle(FRAME_LEN - 1);
      frame(mk(1'b0, 1'b1, 0));
   endtask

   initial begin
      test_reset();
      test_auto_epoch();
      test_pause();
      test_reseed_next();
      test_manual();
      test_reset_in_pause();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d unconsumed expectations, want 0", exp_q.size());
      end
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
